nibble_serial_addsub16: RTL and testbench

Multi-cycle 16-bit signed add/subtract unit that processes one 4-bit nibble per clock, LSB nibble first, with a registered carry between nibbles. It sits in the ALU path and takes operands from the decode/register-read stage. Its registered result and flags (sum, ovfl, neg, zero) drive the flag register and writeback mux directly. It provides a low-area alternative to a full 16-bit combinational adder chain.

---
 rtl/nibble_serial_addsub16.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_addsub16.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub16.sv
// Nibble-serial signed add/subtract: one NIB-bit slice per clock, LSB first, registered carry between slices.
// Optional build macro SAT_EN: saturate the loaded result on signed overflow instead of wrapping.
module nibble_serial_addsub16 #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             neg,
    output logic             zero
);

    localparam int NUM  = WIDTH / NIB;
    localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sub_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  partial_q;
    logic [WIDTH-1:0]  sum_q;
    logic              busy_q;
    logic              done_q;
    logic              ovfl_q;
    logic              neg_q;
    logic              zero_q;

    logic [NIB-1:0]    a_nib_s;
    logic [NIB-1:0]    b_nib_s;
    logic [NIB-1:0]    lo_s;
    logic [1:0]        hi_s;
    logic [NIB-1:0]    nib_sum_s;
    logic              carry_d;
    logic              ovfl_d;
    logic [WIDTH-1:0]  partial_d;
    logic [WIDTH-1:0]  sum_d;
    logic              neg_d;
    logic              zero_d;

    // Slice adder split below the MSB so the carry into bit NIB-1 is visible for overflow detection.
    always_comb begin
        a_nib_s   = a_q[idx_q*NIB +: NIB];
        b_nib_s   = b_q[idx_q*NIB +: NIB] ^ {NIB{sub_q}};
        lo_s      = {1'b0, a_nib_s[NIB-2:0]} + {1'b0, b_nib_s[NIB-2:0]} + {{(NIB-1){1'b0}}, carry_q};
        hi_s      = {1'b0, a_nib_s[NIB-1]} + {1'b0, b_nib_s[NIB-1]} + {1'b0, lo_s[NIB-1]};
        nib_sum_s = {hi_s[0], lo_s[NIB-2:0]};
        carry_d   = hi_s[1];
        ovfl_d    = lo_s[NIB-1] ^ hi_s[1];
        partial_d = partial_q;
        partial_d[idx_q*NIB +: NIB] = nib_sum_s;
`ifdef SAT_EN
        if (ovfl_d) begin
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_d = partial_d;
        end
`else
        sum_d     = partial_d;
`endif
        neg_d     = sum_d[WIDTH-1];
        zero_d    = (sum_d == {WIDTH{1'b0}});
    end

    // Control FSM with operand capture, slice accumulation and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= {IDXW{1'b0}};
            partial_q <= {WIDTH{1'b0}};
            sum_q     <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovfl_q    <= 1'b0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        sub_q     <= sub;
                        carry_q   <= sub;
                        idx_q     <= {IDXW{1'b0}};
                        partial_q <= {WIDTH{1'b0}};
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                RUN: begin
                    partial_q <= partial_d;
                    carry_q   <= carry_d;
                    idx_q     <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= sum_d;
                        ovfl_q  <= ovfl_d;
                        neg_q   <= neg_d;
                        zero_q  <= zero_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovfl = ovfl_q;
    assign neg  = neg_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub16.sv
// Directed bench for nibble_serial_addsub16; expectations follow SAT_EN when the macro is defined.
module tb_nibble_serial_addsub16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        ovfl;
    logic        neg;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    nibble_serial_addsub16 #(.WIDTH(16), .NIB(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovfl  (ovfl),
        .neg   (neg),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after E0, and check latency, pulse shape and results.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic [15:0] es, input logic eo,
                          input logic en, input logic ez);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = 16'h5A5A; sub = ~ts;
        chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 4) chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_ovfl"}, {31'd0, ovfl}, {31'd0, eo});
        chk({tag, "_neg"}, {31'd0, neg}, {31'd0, en});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {29'd0, ovfl, neg, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1_add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
`ifdef SAT_EN
        run_op("t2_posov", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        run_op("t3_negov", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("t7_negadd", 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        run_op("t2_posov", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("t3_negov", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        run_op("t7_negadd", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`endif
        run_op("t4_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("t4_m1", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        run_op("t8_carry", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("t9_negsub", 16'hFFFB, 16'hFFFD, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h7000; b = 16'h7000; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                chk("t5_sum", {16'd0, sum}, 32'h0003);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk("t5_pulses", pulses, 32'd1);
        chk("t5_busy_idle", {31'd0, busy}, 32'd0);

        // Reset during the second RUN cycle.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_sum", {16'd0, sum}, 32'd0);
        chk("t6_flags", {29'd0, ovfl, neg, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("t6_quiet", pulses, 32'd0);
        run_op("t6_fresh", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
